// File: rtl/rs232rx_fifo.sv
// Receive buffer behind the RS232 receiver: a first-word-fall-through FIFO with
// hysteretic RTS flow control and sticky/saturating overflow accounting.
module rs232rx_fifo #(
  parameter int unsigned DEPTH_LOG2 = 4,
  parameter int unsigned HIGH_WATER = 12,
  parameter int unsigned LOW_WATER  = 4
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [7:0]            in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic                  in_overflow,
  output logic [7:0]            out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DEPTH_LOG2:0]   level,
  output logic                  rts_n,
  output logic                  overflow_seen,
  output logic [7:0]            drop_count,
  input  logic                  clear_errors
);

  localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
  localparam int unsigned LVL_W = DEPTH_LOG2 + 1;
  localparam int unsigned PTR_W = DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] LP_FULL = LVL_W'(DEPTH);
  localparam logic [DEPTH_LOG2:0] LP_HIGH = LVL_W'(HIGH_WATER);
  localparam logic [DEPTH_LOG2:0] LP_LOW  = LVL_W'(LOW_WATER);

  logic [7:0]            r_mem [DEPTH];
  logic [PTR_W-1:0]      r_wr_ptr;
  logic [PTR_W-1:0]      r_rd_ptr;
  logic [DEPTH_LOG2:0]   r_level;
  logic                  r_rts_n;
  logic                  r_overflow_seen;
  logic [7:0]            r_drop_count;

  logic                  w_full;
  logic                  w_empty;
  logic                  w_wr;
  logic                  w_rd;
  logic [DEPTH_LOG2:0]   w_level_next;

  assign w_full   = (r_level == LP_FULL);
  assign w_empty  = (r_level == '0);
  assign w_wr     = in_valid & ~w_full;
  assign w_rd     = out_ready & ~w_empty;

  assign in_ready      = ~w_full;
  assign out_valid     = ~w_empty;
  assign out_data      = r_mem[r_rd_ptr];
  assign level         = r_level;
  assign rts_n         = r_rts_n;
  assign overflow_seen = r_overflow_seen;
  assign drop_count    = r_drop_count;

  always_comb begin
    w_level_next = r_level;
    case ({w_wr, w_rd})
      2'b10:   w_level_next = r_level + LVL_W'(1);
      2'b01:   w_level_next = r_level - LVL_W'(1);
      default: w_level_next = r_level;
    endcase
  end

  // Storage is deliberately not reset; only the pointers define its contents.
  always_ff @(posedge clock) begin
    if (w_wr) begin
      r_mem[r_wr_ptr] <= in_data;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
      r_rts_n  <= 1'b0;
    end else begin
      if (w_wr) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_rd) r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      r_level <= w_level_next;
      // Hysteresis: thresholds are applied to the level this edge produces.
      if (!r_rts_n && (w_level_next >= LP_HIGH)) begin
        r_rts_n <= 1'b1;
      end else if (r_rts_n && (w_level_next <= LP_LOW)) begin
        r_rts_n <= 1'b0;
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_overflow_seen <= 1'b0;
      r_drop_count    <= '0;
    end else if (in_overflow) begin
      // A lost byte in the same cycle as a clear is still recorded.
      r_overflow_seen <= 1'b1;
      if (clear_errors) begin
        r_drop_count <= 8'd1;
      end else if (r_drop_count != '1) begin
        r_drop_count <= r_drop_count + 8'd1;
      end
    end else if (clear_errors) begin
      r_overflow_seen <= 1'b0;
      r_drop_count    <= '0;
    end
  end

endmodule

// File: tb/tb_rs232rx_fifo.sv
// Self-checking bench for rs232rx_fifo against a queue-based reference model.
module tb_rs232rx_fifo;

  logic       clock = 1'b0;
  logic       reset;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_ready;
  logic       in_overflow;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ready;
  logic [4:0] level;
  logic       rts_n;
  logic       overflow_seen;
  logic [7:0] drop_count;
  logic       clear_errors;

  int unsigned checks = 0;
  int unsigned errors = 0;

  // Reference model state
  byte unsigned m_q[$];
  bit           m_rts;
  bit           m_seen;
  int unsigned  m_drop;

  rs232rx_fifo #(.DEPTH_LOG2(4), .HIGH_WATER(12), .LOW_WATER(4)) dut (
    .clock(clock), .reset(reset), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .in_overflow(in_overflow), .out_data(out_data),
    .out_valid(out_valid), .out_ready(out_ready), .level(level), .rts_n(rts_n),
    .overflow_seen(overflow_seen), .drop_count(drop_count),
    .clear_errors(clear_errors)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_state();
    check("level", 32'(level), 32'(m_q.size()));
    check("out_valid", 32'(out_valid), 32'(m_q.size() != 0));
    check("in_ready", 32'(in_ready), 32'(m_q.size() < 16));
    check("rts_n", 32'(rts_n), 32'(m_rts));
    check("overflow_seen", 32'(overflow_seen), 32'(m_seen));
    check("drop_count", 32'(drop_count), 32'(m_drop));
    if (m_q.size() != 0) check("out_data", 32'(out_data), 32'(m_q[0]));
  endtask

  task automatic model_reset();
    m_q.delete();
    m_rts  = 1'b0;
    m_seen = 1'b0;
    m_drop = 0;
  endtask

  // One clock: decide transfers from pre-edge model, advance, then compare.
  task automatic step(output bit accepted);
    bit acc, rd;
    acc = in_valid && (m_q.size() < 16);
    rd  = out_ready && (m_q.size() != 0);
    @(posedge clock);
    #1;
    if (rd) void'(m_q.pop_front());
    if (acc) m_q.push_back(in_data);
    if (!m_rts && m_q.size() >= 12) m_rts = 1'b1;
    else if (m_rts && m_q.size() <= 4) m_rts = 1'b0;
    if (in_overflow) begin
      m_seen = 1'b1;
      m_drop = clear_errors ? 1 : ((m_drop < 255) ? m_drop + 1 : 255);
    end else if (clear_errors) begin
      m_seen = 1'b0;
      m_drop = 0;
    end
    accepted = acc;
    check_state();
  endtask

  initial begin
    bit acc;
    int unsigned sent;
    int unsigned got;
    int unsigned budget;
    byte unsigned exp_stream[$];

    reset = 1'b1; in_data = '0; in_valid = 1'b0; in_overflow = 1'b0;
    out_ready = 1'b0; clear_errors = 1'b0;
    model_reset();
    #12;
    check_state();
    @(posedge clock); #3 reset = 1'b0;

    // 1: single byte fall-through then drain
    in_valid = 1'b1; in_data = 8'h41; out_ready = 1'b1;
    step(acc);
    check("t1_out_data", 32'(out_data), 32'h41);
    in_valid = 1'b0;
    step(acc);
    check("t1_level_after_read", 32'(level), 32'd0);

    // 2: fill to full, then a 17th byte is refused
    out_ready = 1'b0;
    for (int i = 0; i < 16; i++) begin
      in_valid = 1'b1; in_data = 8'(i);
      step(acc);
    end
    check("t2_full_ready", 32'(in_ready), 32'd0);
    in_data = 8'h10;
    step(acc);
    check("t2_not_written", 32'(acc), 32'd0);
    in_valid = 1'b0;

    // 3: read 12 bytes from full
    out_ready = 1'b1;
    for (int i = 0; i < 12; i++) begin
      check("t3_seq", 32'(out_data), 32'(i));
      step(acc);
    end
    check("t3_rts_low", 32'(rts_n), 32'd0);
    out_ready = 1'b1;
    while (m_q.size() != 0) step(acc);

    // 4: random stream across pointer wrap
    sent = 0; got = 0; budget = 0;
    while ((got < 40) && (budget < 1000)) begin
      in_valid = (sent < 40);
      if (in_valid) in_data = 8'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      if (out_ready && out_valid) begin
        check("t4_order", 32'(out_data), 32'(exp_stream[0]));
        void'(exp_stream.pop_front());
        got++;
      end
      step(acc);
      if (acc) begin
        exp_stream.push_back(in_data);
        sent++;
      end
      check("t4_level_max", 32'(level <= 5'd16), 32'd1);
      budget++;
    end
    check("t4_completed", 32'(got), 32'd40);
    in_valid = 1'b0; out_ready = 1'b0;

    // 5: saturating drop counter and clear/event collision
    in_overflow = 1'b1;
    for (int i = 0; i < 300; i++) step(acc);
    check("t5_sat", 32'(drop_count), 32'd255);
    clear_errors = 1'b1;
    step(acc);
    check("t5_clear_collide", 32'(drop_count), 32'd1);
    in_overflow = 1'b0;
    step(acc);
    check("t5_cleared", 32'(overflow_seen), 32'd0);
    clear_errors = 1'b0;

    // 6: async reset at level 7, then held byte after release
    in_valid = 1'b1;
    for (int i = 0; i < 7; i++) begin
      in_data = 8'($urandom);
      step(acc);
    end
    in_valid = 1'b0;
    #2 reset = 1'b1;
    #1;
    model_reset();
    check("t6_level", 32'(level), 32'd0);
    check("t6_out_valid", 32'(out_valid), 32'd0);
    check("t6_rts", 32'(rts_n), 32'd0);
    in_valid = 1'b1; in_data = 8'h5A;
    @(posedge clock); #3 reset = 1'b0;
    step(acc);
    check("t6_first", 32'(out_data), 32'h5A);
    in_valid = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
